// File: rtl/demux_1xn_stream.sv
// Registered 1-to-N packet demultiplexer with valid/ready on every port; the channel is locked
// on the first beat of a packet. Optional macro DEMUX_SEL_ERR_EN adds a sticky out-of-range error flag.
module demux_1xn_stream #(
  parameter int N_CH  = 8,
  parameter int SEL_W = 3,
  parameter int DW    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DW-1:0]        in_data,
  input  logic [SEL_W-1:0]     in_sel,
  input  logic                 in_last,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [N_CH*DW-1:0]   out_data,
  output logic [N_CH-1:0]      out_last,
  output logic [N_CH-1:0]      out_valid,
  input  logic [N_CH-1:0]      out_ready,
`ifdef DEMUX_SEL_ERR_EN
  input  logic                 err_clr,
  output logic                 err,
`endif
  output logic                 busy
);

  typedef enum logic {IDLE, ROUTE} state_t;

  localparam logic [SEL_W:0] N_CH_L = (SEL_W+1)'(N_CH);

  state_t            state, state_nxt;
  logic [SEL_W-1:0]  cur_sel, cur_sel_nxt;
  logic [SEL_W-1:0]  chan;
  logic              in_range;
  logic              slot_sel_free;
  logic              accept;
  logic [N_CH-1:0]   slot_free;
  logic [N_CH-1:0]   load;

  // Channel decode and handshake; only the addressed channel's slot gates in_ready.
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    chan          = (state == ROUTE) ? cur_sel : in_sel;
    in_range      = {1'b0, chan} < N_CH_L;
    slot_free     = ~out_valid | out_ready;
    slot_sel_free = 1'b0;
    for (int c = 0; c < N_CH; c++) begin
      if (chan == SEL_W'(c)) slot_sel_free = slot_free[c];
    end
    in_ready = in_range ? slot_sel_free : 1'b1;
    accept   = in_valid & in_ready;
    load     = '0;
    for (int c = 0; c < N_CH; c++) begin
      load[c] = accept & (chan == SEL_W'(c));
    end
  end

  always_comb begin
    state_nxt   = state;
    cur_sel_nxt = cur_sel;
    case (state)
      IDLE:    if (accept && !in_last) begin
                 state_nxt   = ROUTE;
                 cur_sel_nxt = in_sel;
               end
      ROUTE:   if (accept && in_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cur_sel <= '0;
    end else begin
      state   <= state_nxt;
      cur_sel <= cur_sel_nxt;
    end
  end

  assign busy = (state == ROUTE);

  // Per-channel one-entry holding registers; a load wins over a same-cycle drain.
  // NOTE: data/last registers are reset too, so consumers never see X on an idle channel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= '0;
      out_data  <= '0;
      out_last  <= '0;
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        if (load[c]) begin
          out_valid[c]          <= 1'b1;
          out_data[c*DW +: DW]  <= in_data;
          out_last[c]           <= in_last;
        end else if (out_ready[c]) begin
          out_valid[c] <= 1'b0;
        end
      end
    end
  end

`ifdef DEMUX_SEL_ERR_EN
  logic err_set;

  // Flag only the first beat of a dropped packet; a simultaneous clear loses to the set.
  assign err_set = accept & (state == IDLE) & ~in_range;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       err <= 1'b0;
    else if (err_set) err <= 1'b1;
    else if (err_clr) err <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_demux_1xn_stream.sv
// Self-checking bench for demux_1xn_stream (N_CH=6 so selects 6 and 7 are out of range):
// a queue-based per-channel model checked every cycle, plus directed literal checks.
module tb_demux_1xn_stream;
  localparam int N_CH  = 6;
  localparam int SEL_W = 3;
  localparam int DW    = 8;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [DW-1:0]        in_data = '0;
  logic [SEL_W-1:0]     in_sel = '0;
  logic                 in_last = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [N_CH*DW-1:0]   out_data;
  logic [N_CH-1:0]      out_last;
  logic [N_CH-1:0]      out_valid;
  logic [N_CH-1:0]      out_ready = '1;
  logic                 busy;
`ifdef DEMUX_SEL_ERR_EN
  logic                 err_clr = 1'b0;
  logic                 err;
`endif

  int checks = 0;
  int failures = 0;

  demux_1xn_stream #(.N_CH(N_CH), .SEL_W(SEL_W), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_sel(in_sel), .in_last(in_last), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
`ifdef DEMUX_SEL_ERR_EN
    .err_clr(err_clr), .err(err),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: each channel is a FIFO of at most one beat; a packet's channel is fixed by its first beat.
  typedef struct packed { logic last; logic [DW-1:0] data; } beat_t;
  beat_t mq[N_CH][$];
  beat_t m_hold[N_CH];
  bit    m_busy = 1'b0;
  int    m_sel = 0;
`ifdef DEMUX_SEL_ERR_EN
  bit    m_err = 1'b0;
`endif

  function automatic int m_chan();
    return m_busy ? m_sel : int'(in_sel);
  endfunction

  function automatic bit m_ready();
    int ch = m_chan();
    if (ch >= N_CH) return 1'b1;
    return (mq[ch].size() == 0) || out_ready[ch];
  endfunction

  initial begin
    for (int c = 0; c < N_CH; c++) m_hold[c] = '0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int c = 0; c < N_CH; c++) begin
          mq[c].delete();
          m_hold[c] = '0;
        end
        m_busy = 1'b0;
        m_sel  = 0;
`ifdef DEMUX_SEL_ERR_EN
        m_err  = 1'b0;
`endif
      end else begin
        int ch;
        bit rdy;
        bit set;
        ch  = m_chan();
        rdy = m_ready();
        set = 1'b0;
        for (int c = 0; c < N_CH; c++)
          if (mq[c].size() != 0 && out_ready[c]) void'(mq[c].pop_front());
        if (in_valid && rdy) begin
          if (ch < N_CH) begin
            mq[ch].push_back({in_last, in_data});
            m_hold[ch] = {in_last, in_data};
          end else if (!m_busy) begin
            set = 1'b1;
          end
          if (!m_busy && !in_last) begin
            m_busy = 1'b1;
            m_sel  = int'(in_sel);
          end else if (m_busy && in_last) begin
            m_busy = 1'b0;
          end
        end
`ifdef DEMUX_SEL_ERR_EN
        if (set) m_err = 1'b1;
        else if (err_clr) m_err = 1'b0;
`endif
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial forever begin
    logic [N_CH-1:0]    ev;
    logic [N_CH-1:0]    el;
    logic [N_CH*DW-1:0] ed;
    beat_t              b;
    @(negedge clk);
    for (int c = 0; c < N_CH; c++) begin
      ev[c] = (mq[c].size() != 0);
      b     = ev[c] ? mq[c][0] : m_hold[c];
      ed[c*DW +: DW] = b.data;
      el[c] = b.last;
    end
    check("model out_valid", 64'(out_valid), 64'(ev));
    check("model out_data",  64'(out_data),  64'(ed));
    check("model out_last",  64'(out_last),  64'(el));
    check("model busy",      64'(busy),      64'(m_busy));
    check("model in_ready",  64'(in_ready),  64'(m_ready()));
`ifdef DEMUX_SEL_ERR_EN
    check("model err",       64'(err),       64'(m_err));
`endif
  end

  // Delivery log: handshakes seen at negedge complete on the following posedge.
  int              cyc = 0;
  int              log_ch[$];
  logic [DW-1:0]   log_dat[$];
  int              log_cyc[$];

  initial forever begin
    @(negedge clk);
    cyc++;
    for (int c = 0; c < N_CH; c++) begin
      if (rst_n && out_valid[c] && out_ready[c]) begin
        log_ch.push_back(c);
        log_dat.push_back(out_data[c*DW +: DW]);
        log_cyc.push_back(cyc);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic present(input logic [SEL_W-1:0] sel, input logic [DW-1:0] data, input logic last);
    in_valid = 1'b1;
    in_sel   = sel;
    in_data  = data;
    in_last  = last;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_accept(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check({name, " accepted"}, 64'(ok), 64'(1));
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [SEL_W-1:0] sel, input logic [DW-1:0] data, input logic last,
                      input string name);
    present(sel, data, last);
    wait_accept(name);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n3;
    logic [DW-1:0] d3[$];

    // Reset state
    #2;
    check("reset out_valid", 64'(out_valid), 64'h0);
    check("reset out_data",  64'(out_data),  64'h0);
    check("reset busy",      64'(busy),      64'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(1);

    // Single beat to channel 5
    send(3'd5, 8'hA5, 1'b1, "single");
    idle();
    check("single out_valid", 64'(out_valid), 64'h20);
    check("single ch5 data",  64'(out_data[5*DW +: DW]), 64'hA5);
    check("single ch5 last",  64'(out_last[5]), 64'h1);
    step(1);
    check("single drained",   64'(out_valid), 64'h00);
    check("single data hold", 64'(out_data[5*DW +: DW]), 64'hA5);

    // Packet lock: select changes after beat 0 are ignored
    for (int i = 0; i < 4; i++) begin
      check("lock busy", 64'(busy), 64'(i > 0));
      send((i == 0) ? 3'd2 : 3'd7, 8'(i + 1), i == 3, "lock");
      check("lock out_valid", 64'(out_valid), 64'h04);
      check("lock ch2 data",  64'(out_data[2*DW +: DW]), 64'(i + 1));
    end
    idle();
    check("lock busy end", 64'(busy), 64'h0);
    step(1);

    // Backpressure on channel 3
    log_ch.delete(); log_dat.delete(); log_cyc.delete();
    out_ready = 6'b110111;
    send(3'd3, 8'h31, 1'b0, "bp0");
    present(3'd3, 8'h32, 1'b1);
    @(negedge clk);
    check("bp stall in_ready", 64'(in_ready), 64'h0);
    repeat (3) begin
      @(negedge clk);
      check("bp hold valid", 64'(out_valid[3]), 64'h1);
      check("bp hold data",  64'(out_data[3*DW +: DW]), 64'h31);
    end
    @(posedge clk);
    #1 out_ready = '1;
    wait_accept("bp1");
    idle();
    step(2);
    n3 = 0;
    for (int i = 0; i < log_ch.size(); i++)
      if (log_ch[i] == 3) begin
        n3++;
        d3.push_back(log_dat[i]);
      end
    check("bp delivered count", 64'(n3), 64'd2);
    if (n3 == 2) begin
      check("bp first beat",  64'(d3[0]), 64'h31);
      check("bp second beat", 64'(d3[1]), 64'h32);
    end

    // Throughput: 16 back-to-back beats to channel 0
    log_ch.delete(); log_dat.delete(); log_cyc.delete();
    for (int i = 0; i < 16; i++) send(3'd0, 8'(8'h40 + i), i == 15, "tput");
    idle();
    step(2);
    check("tput count", 64'(log_ch.size()), 64'd16);
    if (log_ch.size() == 16)
      for (int i = 0; i < 16; i++) begin
        check("tput data",  64'(log_dat[i]), 64'(8'h40 + i));
        check("tput cycle", 64'(log_cyc[i] - log_cyc[0]), 64'(i));
      end

    // Out-of-range packet (select 7) dropped whole, including in-range selects mid-packet
    for (int i = 0; i < 3; i++) begin
      present((i == 0) ? 3'd7 : 3'd0, 8'(8'hE1 + i), i == 2);
      @(negedge clk);
      check("oor in_ready", 64'(in_ready), 64'h1);
      @(posedge clk);
      #1;
      check("oor out_valid", 64'(out_valid), 64'h0);
`ifdef DEMUX_SEL_ERR_EN
      check("oor err set", 64'(err), 64'h1);
`endif
    end
    idle();
    step(2);
    check("oor busy end", 64'(busy), 64'h0);
`ifdef DEMUX_SEL_ERR_EN
    check("oor err sticky", 64'(err), 64'h1);
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    check("oor err cleared", 64'(err), 64'h0);
    err_clr = 1'b1;
`endif
    // Select 6 single-beat packet (with a concurrent clear when the error flag exists)
    present(3'd6, 8'hE4, 1'b1);
    step(1);
    idle();
`ifdef DEMUX_SEL_ERR_EN
    err_clr = 1'b0;
    check("sel6 set wins", 64'(err), 64'h1);
`endif
    check("sel6 dropped", 64'(out_valid), 64'h0);
    send(3'd1, 8'h11, 1'b1, "after oor");
    idle();
    check("after oor valid", 64'(out_valid), 64'h02);
    step(1);

    // Reset mid-packet with a held beat
    out_ready = 6'b111101;
    send(3'd1, 8'h71, 1'b0, "mid");
    idle();
    check("mid busy",  64'(busy), 64'h1);
    check("mid valid", 64'(out_valid), 64'h02);
    #2 rst_n = 1'b0;
    #1;
    check("async reset valid", 64'(out_valid), 64'h0);
    check("async reset busy",  64'(busy), 64'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = '1;
    step(1);
    send(3'd4, 8'h44, 1'b1, "post reset");
    idle();
    check("post reset valid", 64'(out_valid), 64'h10);
    check("post reset data",  64'(out_data[4*DW +: DW]), 64'h44);
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
